// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: PC, instruction memory and next-PC select.
// Zero-latency combinational read; stall or disable holds the PC and HALT_WORD freezes fetch until reset.
module if_fetch_stage #(
  parameter int          MSB        = 32,
  parameter int          IMEM_DEPTH = 256,
  parameter logic [31:0] HALT_WORD  = 32'hFFFF_FFFF
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_enable,
  input  logic                          stall_ID,
  input  logic                          i_redirect,
  input  logic [MSB-1:0]                i_redirect_pc,
  input  logic                          i_load_en,
  input  logic [$clog2(IMEM_DEPTH)-1:0] i_load_addr,
  input  logic [31:0]                   i_load_data,
  output logic [MSB-1:0]                IF_next_pc,
  output logic [31:0]                   IF_inst,
  output logic                          flush,
  output logic [MSB-1:0]                o_pc,
  output logic                          o_halted
);

  localparam int AW = $clog2(IMEM_DEPTH);

  logic [MSB-1:0] pc;
  logic           halted;
  logic [31:0]    mem [IMEM_DEPTH];
  logic [31:0]    raw_word;
  logic [MSB-1:0] pc_plus4;
  logic [MSB-1:0] redirect_target;
  logic           advance;

  // Upper PC bits are dropped so fetch addresses wrap modulo the memory size.
  assign raw_word        = mem[pc[AW+1:2]];
  assign pc_plus4        = pc + MSB'(4);
  assign redirect_target = i_redirect_pc & ~MSB'(3);
  assign advance         = i_enable & ~halted & ~stall_ID;

  assign flush      = advance & i_redirect;
  assign IF_inst    = halted ? 32'h0 : raw_word;
  assign IF_next_pc = pc_plus4;
  assign o_pc       = pc;
  assign o_halted   = halted;

  always_ff @(posedge i_clk) begin
    if (i_load_en) begin
      mem[i_load_addr] <= i_load_data;
    end
  end

  // A redirect takes priority over a HALT word, so a wrong-path HALT never freezes fetch.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pc     <= '0;
      halted <= 1'b0;
    end else if (advance) begin
      if (i_redirect) begin
        pc <= redirect_target;
      end else if (raw_word == HALT_WORD) begin
        halted <= 1'b1;
      end else begin
        pc <= pc_plus4;
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: vector table plus hand-written halt/reset/load sequences.
module tb_if_fetch_stage;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        i_enable = 1'b0;
  logic        stall_ID = 1'b0;
  logic        i_redirect = 1'b0;
  logic [31:0] i_redirect_pc = '0;
  logic        i_load_en = 1'b0;
  logic [7:0]  i_load_addr = '0;
  logic [31:0] i_load_data = '0;
  logic [31:0] IF_next_pc;
  logic [31:0] IF_inst;
  logic        flush;
  logic [31:0] o_pc;
  logic        o_halted;

  int checks = 0;
  int errors = 0;

  if_fetch_stage dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_enable     (i_enable),
    .stall_ID     (stall_ID),
    .i_redirect   (i_redirect),
    .i_redirect_pc(i_redirect_pc),
    .i_load_en    (i_load_en),
    .i_load_addr  (i_load_addr),
    .i_load_data  (i_load_data),
    .IF_next_pc   (IF_next_pc),
    .IF_inst      (IF_inst),
    .flush        (flush),
    .o_pc         (o_pc),
    .o_halted     (o_halted)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        en;
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] npc;
    logic        fl;
    logic        hl;
  } vec_t;

  vec_t vecs [17];

  // Inputs change on the falling edge and outputs are sampled 1ns later.
  task automatic cyc(input logic rst, input logic en, input logic stall, input logic redir,
                     input logic [31:0] rpc, input logic ld, input logic [7:0] la,
                     input logic [31:0] ldat);
    @(negedge i_clk);
    i_rst = rst; i_enable = en; stall_ID = stall; i_redirect = redir; i_redirect_pc = rpc;
    i_load_en = ld; i_load_addr = la; i_load_data = ldat;
    #1;
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] pc, input logic [31:0] inst,
                     input logic [31:0] npc, input logic fl, input logic hl);
    chk32({name, ".o_pc"}, o_pc, pc);
    chk32({name, ".IF_inst"}, IF_inst, inst);
    chk32({name, ".IF_next_pc"}, IF_next_pc, npc);
    chk32({name, ".flush"}, {31'b0, flush}, {31'b0, fl});
    chk32({name, ".o_halted"}, {31'b0, o_halted}, {31'b0, hl});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    //           en stall redir rpc         pc          inst          npc         fl hl
    vecs[0]  = '{1, 0, 0, 32'h0,   32'h0,   32'h1000_0001, 32'h4,   0, 0};
    vecs[1]  = '{1, 0, 0, 32'h0,   32'h4,   32'h1000_0002, 32'h8,   0, 0};
    vecs[2]  = '{1, 1, 0, 32'h0,   32'h8,   32'h1000_0003, 32'hC,   0, 0};
    vecs[3]  = '{1, 1, 1, 32'h40,  32'h8,   32'h1000_0003, 32'hC,   0, 0};
    vecs[4]  = '{1, 0, 0, 32'h0,   32'h8,   32'h1000_0003, 32'hC,   0, 0};
    vecs[5]  = '{1, 0, 0, 32'h0,   32'hC,   32'h1000_0004, 32'h10,  0, 0};
    vecs[6]  = '{0, 0, 0, 32'h0,   32'h10,  32'h1000_0005, 32'h14,  0, 0};
    vecs[7]  = '{0, 0, 0, 32'h0,   32'h10,  32'h1000_0005, 32'h14,  0, 0};
    vecs[8]  = '{1, 0, 1, 32'h23,  32'h10,  32'h1000_0005, 32'h14,  1, 0};
    vecs[9]  = '{1, 0, 0, 32'h0,   32'h20,  32'h1000_0009, 32'h24,  0, 0};
    vecs[10] = '{0, 0, 1, 32'h80,  32'h24,  32'h1000_000A, 32'h28,  0, 0};
    vecs[11] = '{1, 0, 0, 32'h0,   32'h24,  32'h1000_000A, 32'h28,  0, 0};
    vecs[12] = '{1, 0, 1, 32'h400, 32'h28,  32'h1000_000B, 32'h2C,  1, 0};
    vecs[13] = '{0, 0, 0, 32'h0,   32'h400, 32'h1000_0001, 32'h404, 0, 0};
    vecs[14] = '{1, 0, 0, 32'h0,   32'h400, 32'h1000_0001, 32'h404, 0, 0};
    vecs[15] = '{0, 0, 0, 32'h0,   32'h404, 32'h1000_0002, 32'h408, 0, 0};
    vecs[16] = '{0, 0, 0, 32'h0,   32'h404, 32'h1000_0002, 32'h408, 0, 0};

    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    chk("reset", 32'h0, IF_inst, 32'h4, 0, 0);

    // Load with fetch disabled; PC must stay at 0 throughout.
    for (int i = 0; i < 16; i++) begin
      cyc(0, 0, 0, 0, 0, 1, 8'(i), 32'h1000_0001 + 32'(i));
      if (i == 8) chk32("load_pc_frozen", o_pc, 32'h0);
    end

    for (int i = 0; i < 17; i++) begin
      cyc(0, vecs[i].en, vecs[i].stall, vecs[i].redir, vecs[i].rpc, 0, 0, 0);
      chk($sformatf("vec%0d", i), vecs[i].pc, vecs[i].inst, vecs[i].npc, vecs[i].fl, vecs[i].hl);
    end

    // Halt: word 2 becomes HALT, restart from reset.
    cyc(0, 0, 0, 0, 0, 1, 8'd2, 32'hFFFF_FFFF);
    cyc(1, 1, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0, 0);
    chk("halt_pc0", 32'h0, 32'h1000_0001, 32'h4, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0, 0);
    chk("halt_pc4", 32'h4, 32'h1000_0002, 32'h8, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0, 0);
    chk("halt_fetch", 32'h8, 32'hFFFF_FFFF, 32'hC, 0, 0);
    for (int i = 0; i < 10; i++) begin
      cyc(0, 1, 0, (i == 5), 32'h40, 0, 0, 0);
      chk($sformatf("halted%0d", i), 32'h8, 32'h0, 32'hC, 0, 1);
    end
    cyc(1, 1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    chk("halt_reset", 32'h0, 32'h1000_0001, 32'h4, 0, 0);

    // HALT in the shadow of a redirect is squashed.
    cyc(0, 1, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0, 0);
    chk("squash_pc4", 32'h4, 32'h1000_0002, 32'h8, 0, 0);
    cyc(0, 1, 0, 1, 32'h30, 0, 0, 0);
    chk("squash_redir", 32'h8, 32'hFFFF_FFFF, 32'hC, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    chk("squash_target", 32'h30, 32'h1000_000D, 32'h34, 0, 0);

    // Same-cycle write returns old data, new data next cycle.
    cyc(0, 0, 0, 0, 0, 1, 8'd12, 32'hABCD_0000);
    chk32("load_old_data", IF_inst, 32'h1000_000D);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    chk32("load_new_data", IF_inst, 32'hABCD_0000);

    // Reset wins over stall and over redirect.
    cyc(1, 1, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    chk32("rst_mid_stall", o_pc, 32'h0);
    cyc(0, 1, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 1, 32'h40, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    chk32("rst_mid_redirect", o_pc, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
